// File: rtl/axil_mult_pkg.sv
// rtl/axil_mult_pkg.sv - shared constants, state types and address field positions for the multiply-table slave
package axil_mult_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Read address layout: [5:3] = a, [2:0] = b, bits above FIELD_TOP are out of table range
    localparam int A_LSB     = 3;
    localparam int A_MSB     = 5;
    localparam int B_LSB     = 0;
    localparam int B_MSB     = 2;
    localparam int FIELD_W   = 3;
    localparam int PROD_W    = 6;
    localparam int FIELD_TOP = 6;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_CALC,
        RD_RESP
    } rd_state_t;

    typedef enum logic {
        WR_IDLE,
        WR_RESP
    } wr_state_t;

endpackage

// File: rtl/mult_lut.sv
// rtl/mult_lut.sv - combinational 3-bit x 3-bit -> 6-bit product table
module mult_lut
    import axil_mult_pkg::*;
(
    input  logic [FIELD_W-1:0] a,
    input  logic [FIELD_W-1:0] b,
    output logic [PROD_W-1:0]  product
);

    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] b_ext;

    assign a_ext = {{(PROD_W-FIELD_W){1'b0}}, a};
    assign b_ext = {{(PROD_W-FIELD_W){1'b0}}, b};

    // Largest product is 7*7 = 49, so six bits never overflow
    assign product = a_ext * b_ext;

endmodule

// File: rtl/axi_lite_mult_slave.sv
// rtl/axi_lite_mult_slave.sv - AXI-Lite read-only multiply table; optional AXIL_MULT_RANGE_CHECK_EN flags out-of-range reads
module axi_lite_mult_slave
    import axil_mult_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,

    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,

    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,

    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,

    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready
);

    rd_state_t          rd_state;
    rd_state_t          rd_next;
    logic [FIELD_W-1:0] a_q;
    logic [FIELD_W-1:0] b_q;
    logic               range_err_q;
    logic               range_hit;
    logic [PROD_W-1:0]  product;
    logic               ar_hs;
    logic               r_hs;

    wr_state_t          wr_state;
    wr_state_t          wr_next;
    logic               aw_done;
    logic               w_done;
    logic               aw_next;
    logic               w_next;
    logic               aw_hs;
    logic               w_hs;
    logic               b_hs;

    // Write payload and write address carry no meaning for a read-only table
    logic               unused_inputs;
    assign unused_inputs = ^{s_axi_awaddr, s_axi_wdata, s_axi_wstrb,
                             s_axi_araddr[ADDR_W-1:FIELD_TOP]};

    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign r_hs  = s_axi_rvalid && s_axi_rready;
    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign b_hs  = s_axi_bvalid && s_axi_bready;

`ifdef AXIL_MULT_RANGE_CHECK_EN
    assign range_hit = |s_axi_araddr[ADDR_W-1:FIELD_TOP];
`else
    assign range_hit = 1'b0;
`endif

    mult_lut u_mult_lut (
        .a       (a_q),
        .b       (b_q),
        .product (product)
    );

    // Read FSM next state: one outstanding read, fixed one-cycle calculation
    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (ar_hs) rd_next = RD_CALC;
            RD_CALC: rd_next = RD_RESP;
            RD_RESP: if (r_hs) rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    // Read path registers; rvalid trails entry into RD_RESP by one edge so rdata has settled a full cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state      <= RD_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
            a_q           <= '0;
            b_q           <= '0;
            range_err_q   <= 1'b0;
        end else begin
            rd_state      <= rd_next;
            s_axi_arready <= (rd_next == RD_IDLE);
            s_axi_rvalid  <= (rd_state == RD_RESP) && !r_hs;
            if (rd_state == RD_IDLE && ar_hs) begin
                a_q         <= s_axi_araddr[A_MSB:A_LSB];
                b_q         <= s_axi_araddr[B_MSB:B_LSB];
                range_err_q <= range_hit;
            end
            if (rd_state == RD_CALC) begin
                if (range_err_q) begin
                    s_axi_rdata <= '0;
                    s_axi_rresp <= RESP_SLVERR;
                end else begin
                    s_axi_rdata <= {{(DATA_W-PROD_W){1'b0}}, product};
                    s_axi_rresp <= RESP_OKAY;
                end
            end
        end
    end

    // Write FSM next state: AW and W captured independently, error response once both are in
    always_comb begin
        wr_next = wr_state;
        aw_next = aw_done || aw_hs;
        w_next  = w_done || w_hs;
        case (wr_state)
            WR_IDLE: if (aw_next && w_next) wr_next = WR_RESP;
            WR_RESP: begin
                if (b_hs) begin
                    wr_next = WR_IDLE;
                    aw_next = 1'b0;
                    w_next  = 1'b0;
                end
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    // Write path registers; every write is refused because the table is read-only
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state      <= WR_IDLE;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
        end else begin
            wr_state      <= wr_next;
            aw_done       <= aw_next;
            w_done        <= w_next;
            s_axi_awready <= (wr_next == WR_IDLE) && !aw_next;
            s_axi_wready  <= (wr_next == WR_IDLE) && !w_next;
            s_axi_bvalid  <= (wr_next == WR_RESP);
            if (wr_next == WR_RESP) s_axi_bresp <= RESP_SLVERR;
        end
    end

endmodule

// File: tb/tb_axi_lite_mult_slave.sv
// tb/tb_axi_lite_mult_slave.sv - self-checking bench for the multiply-table slave
module tb_axi_lite_mult_slave;
    import axil_mult_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                clk;
    logic                rst;
    logic [ADDR_W-1:0]   s_axi_araddr;
    logic                s_axi_arvalid;
    logic                s_axi_arready;
    logic [DATA_W-1:0]   s_axi_rdata;
    logic [1:0]          s_axi_rresp;
    logic                s_axi_rvalid;
    logic                s_axi_rready;
    logic [ADDR_W-1:0]   s_axi_awaddr;
    logic                s_axi_awvalid;
    logic                s_axi_awready;
    logic [DATA_W-1:0]   s_axi_wdata;
    logic [DATA_W/8-1:0] s_axi_wstrb;
    logic                s_axi_wvalid;
    logic                s_axi_wready;
    logic [1:0]          s_axi_bresp;
    logic                s_axi_bvalid;
    logic                s_axi_bready;

    axi_lite_mult_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          rdelay;
        logic [31:0] data;
        logic [1:0]  resp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   vec_count   = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One AR handshake, optional R backpressure, then compare against the scoreboard head
    task automatic do_read(input logic [31:0] addr, input int rdelay,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int   waited;
        int   lat;
        exp_t e;
        waited = 0;
        while (!s_axi_arready && waited < 20) begin
            tick();
            waited++;
        end
        check("arready_idle", s_axi_arready, 1);
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        s_axi_rready  = (rdelay == 0);
        tick();
        s_axi_arvalid = 1'b0;
        e.resp = exp_resp;
        e.data = exp_data;
        sb.push_back(e);
        check("arready_busy", s_axi_arready, 0);
        lat = 0;
        while (!s_axi_rvalid && lat < 10) begin
            tick();
            lat++;
        end
        check("rvalid_latency", lat, 2);
        if (!s_axi_rvalid) begin
            void'(sb.pop_front());
            return;
        end
        for (int i = 0; i < rdelay; i++) begin
            check("rvalid_hold", s_axi_rvalid, 1);
            check("rdata_hold", s_axi_rdata, sb[0].data);
            check("arready_hold", s_axi_arready, 0);
            tick();
        end
        s_axi_rready = 1'b1;
        e = sb.pop_front();
        check("rdata", s_axi_rdata, e.data);
        check("rresp", {30'd0, s_axi_rresp}, {30'd0, e.resp});
        tick();
        s_axi_rready = 1'b0;
        check("rvalid_drop", s_axi_rvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int   lat;
        logic [31:0] exp_p;

        vecs[0] = '{32'h0000_002B, 0, 32'd15, RESP_OKAY};
        vecs[1] = '{32'h0000_003F, 4, 32'd49, RESP_OKAY};
        vecs[2] = '{32'h0000_0000, 0, 32'd0,  RESP_OKAY};
        vecs[3] = '{32'h0000_0012, 2, 32'd4,  RESP_OKAY};
`ifdef AXIL_MULT_RANGE_CHECK_EN
        vecs[4] = '{32'h0000_0040, 0, 32'd0,  RESP_SLVERR};
        vecs[5] = '{32'hFFFF_FFDD, 1, 32'd0,  RESP_SLVERR};
`else
        vecs[4] = '{32'h0000_0040, 0, 32'd0,  RESP_OKAY};
        vecs[5] = '{32'hFFFF_FFDD, 1, 32'd15, RESP_OKAY};
`endif

        rst           = 1'b1;
        s_axi_araddr  = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        s_axi_awaddr  = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        repeat (3) tick();
        check("rst_arready", s_axi_arready, 0);
        check("rst_rvalid", s_axi_rvalid, 0);
        check("rst_rdata", s_axi_rdata, 0);
        check("rst_rresp", {30'd0, s_axi_rresp}, 0);
        check("rst_awready", s_axi_awready, 0);
        check("rst_wready", s_axi_wready, 0);
        check("rst_bvalid", s_axi_bvalid, 0);
        check("rst_bresp", {30'd0, s_axi_bresp}, 0);
        rst = 1'b0;
        tick();
        check("post_rst_arready", s_axi_arready, 1);
        check("post_rst_awready", s_axi_awready, 1);
        check("post_rst_wready", s_axi_wready, 1);

        for (int i = 0; i < 6; i++)
            do_read(vecs[i].addr, vecs[i].rdelay, vecs[i].data, vecs[i].resp);

        for (int addr = 0; addr < 64; addr++) begin
            exp_p = (addr / 8) * (addr % 8);
            do_read(addr, 0, exp_p, RESP_OKAY);
        end

        s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        check("aw_only_awready", s_axi_awready, 0);
        check("aw_only_wready", s_axi_wready, 1);
        check("aw_only_bvalid", s_axi_bvalid, 0);
        tick();
        check("aw_wait_bvalid", s_axi_bvalid, 0);
        s_axi_wvalid = 1'b1;
        tick();
        s_axi_wvalid = 1'b0;
        check("w_late_bvalid", s_axi_bvalid, 1);
        check("w_late_bresp", {30'd0, s_axi_bresp}, {30'd0, RESP_SLVERR});
        check("w_late_wready", s_axi_wready, 0);
        tick();
        check("b_hold_bvalid", s_axi_bvalid, 1);
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        check("b_done_bvalid", s_axi_bvalid, 0);
        check("b_done_awready", s_axi_awready, 1);
        check("b_done_wready", s_axi_wready, 1);

        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        check("aw_w_bvalid", s_axi_bvalid, 1);
        check("aw_w_bresp", {30'd0, s_axi_bresp}, {30'd0, RESP_SLVERR});
        check("aw_w_awready", s_axi_awready, 0);
        check("aw_w_wready", s_axi_wready, 0);
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        check("aw_w_bdone", s_axi_bvalid, 0);

        s_axi_araddr  = 32'h0000_002B;
        s_axi_arvalid = 1'b1;
        s_axi_rready  = 1'b0;
        tick();
        s_axi_arvalid = 1'b0;
        lat = 0;
        while (!s_axi_rvalid && lat < 10) begin
            tick();
            lat++;
        end
        check("pre_abort_rvalid", s_axi_rvalid, 1);
        rst = 1'b1;
        tick();
        check("abort_rvalid", s_axi_rvalid, 0);
        check("abort_arready", s_axi_arready, 0);
        rst = 1'b0;
        tick();
        check("abort_arready_back", s_axi_arready, 1);
        check("abort_no_resp", s_axi_rvalid, 0);
        do_read(32'h0000_0036, 0, 32'd36, RESP_OKAY);

        check("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_lite_mult_slave.md
AXI_LITE_MULT_SLAVE -- requirements
Module: axi_lite_mult_slave

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, AXI address width; DATA_W, 32, AXI data width.
REQ-002 Clock and reset SHALL be one clock and a synchronous, active-high reset, with ports as follows.
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
REQ-003 Read address channel ports:
- s_axi_araddr  in  ADDR_W  read address; [5:3]=a, [2:0]=b.
- s_axi_arvalid  in  1  master address valid.
- s_axi_arready  out  1  slave address ready.
REQ-004 Read data channel ports:
- s_axi_rdata  out  DATA_W  product, zero-extended.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid  out  1  data valid.
- s_axi_rready  in  1  master data ready.
REQ-005 Write address channel ports:
- s_axi_awaddr  in  ADDR_W  ignored.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address ready.
REQ-006 Write data channel ports:
- s_axi_wdata  in  DATA_W  ignored.
- s_axi_wstrb  in  DATA_W/8  ignored.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data ready.
REQ-007 Write response channel ports:
- s_axi_bresp  out  2  write response.
- s_axi_bvalid  out  1  response valid.
- s_axi_bready  in  1  master response ready.

Function
REQ-008 The read FSM SHALL use the states RD_IDLE, RD_CALC and RD_RESP.
- RD_IDLE: arready=1.
- arvalid&&arready moves the FSM to RD_CALC and latches araddr.
REQ-009 RD_CALC SHALL last exactly one cycle: it registers a*b (6 bits, max 49) into rdata[5:0], sets rdata[DATA_W-1:6]=0 and moves to RD_RESP.
REQ-010 RD_RESP SHALL hold rvalid=1 with rdata/rresp stable until rready; rvalid&&rready moves the FSM to RD_IDLE.
REQ-011 Latency: for an AR handshake at edge N, rvalid SHALL rise after edge N+2.
REQ-012 arready SHALL be 0 in RD_CALC and RD_RESP; only one read is outstanding and there is no AR buffering.
REQ-013 rresp SHALL be OKAY (2'b00) unless REQ-021 applies.
REQ-014 The write path SHALL accept AW and W independently.
- awready=1 until AW is captured; wready=1 until W is captured.
- AW and W arriving in the same cycle SHALL both be captured.
REQ-015 The cycle after both AW and W are captured, bvalid SHALL be 1 with bresp=SLVERR (2'b10), because the table is read-only.
REQ-016 bvalid SHALL hold until bready; on bvalid&&bready the capture flags clear and awready/wready return to 1 on the next cycle.
REQ-017 The read and write paths SHALL operate concurrently and not block each other.
REQ-018 No output SHALL depend combinationally on any input; all outputs are registered.

Reset
REQ-019 While rst=1 at a clk edge, the block SHALL set:
- arready=0, rvalid=0, rdata=0, rresp=0;
- awready=0, wready=0, bvalid=0, bresp=0;
- both FSMs to idle and the capture flags cleared.
REQ-020 The first cycle after reset deasserts, arready, awready and wready SHALL be 1; rst asserted mid-transaction SHALL abort it and produce no response.

Configuration
REQ-021 With AXIL_MULT_RANGE_CHECK_EN defined, a read with araddr[ADDR_W-1:6]!=0 SHALL return rresp=SLVERR and rdata=0 with the same latency as a normal read.
REQ-022 Without AXIL_MULT_RANGE_CHECK_EN, araddr[ADDR_W-1:6] SHALL be ignored and rresp is always OKAY.

Structure
REQ-023 Package axil_mult_pkg SHALL hold:
- RESP_OKAY and RESP_SLVERR constants;
- the read-state and write-state typedefs;
- the a/b field bit positions.
REQ-024 Sub-module mult_lut SHALL hold the combinational 3-bit x 3-bit -> 6-bit product, instantiated once.

Verification
REQ-025 The bench SHALL cover these scenarios:
- Reset, then araddr=0x2B (a=5, b=3), rready=1 -> rvalid 2 cycles after handshake, rdata=15, rresp=OKAY.
- araddr=0x3F, rready held 0 for 4 cycles -> rvalid and rdata=49 stable throughout; arready=0 until the R handshake.
- Sweep all 64 addresses back-to-back -> each rdata=a*b and rresp=OKAY.
- AW at cycle 1 and W at cycle 3 -> bvalid at cycle 4 with bresp=2'b10; simultaneous AW+W -> bvalid the next cycle.
- araddr=0x40 -> rresp=SLVERR and rdata=0 with the macro defined; rdata=0 (a=0, b=0) and OKAY without it.
- rst asserted while in RD_RESP -> rvalid=0 on the next edge; a new read then completes normally.
